data_bus_bridge: RTL and testbench

Sits directly downstream of the core's data-memory port. Takes the M-stage address, aligned write data and per-byte write enables, and returns read data one cycle later. Decodes two regions: an on-chip byte-enabled data RAM and a memory-mapped UART transmitter. The UART transmitter has a TX FIFO and an 8N1 serializer driving the board TX pin.

---
 rtl/data_bus_bridge.sv | 196 +++++++++++++++++++
 tb/tb_data_bus_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_bridge.sv
// Data-memory bridge: byte-enabled RAM plus memory-mapped UART TX (FIFO + 8N1 serializer).
// Read data one cycle after the address; no backpressure, TXDATA writes into a full FIFO are dropped and flag overflow.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_wr;
  logic             do_rd;

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;
  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module data_bus_bridge #(
  parameter int RAM_WORDS    = 4096,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  we_i,
  output logic [31:0] rdata_o,
  output logic        uart_tx_o,
  output logic        tx_busy_o
);
  localparam int IDX_W = $clog2(RAM_WORDS);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef struct packed {
    logic busy;
    logic overflow;
    logic empty;
    logic full;
  } status_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic             ram_sel;
  logic             uart_sel;
  logic [IDX_W-1:0] ram_idx;
  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      rd_nxt;
  logic             tx_push;
  logic             status_rd;
  logic             overflow_q;
  status_t          status;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_rd_dat;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
  logic             bit_done;
  logic             unused_addr;

  assign ram_sel     = (addr_i[31:28] == 4'h0);
  assign uart_sel    = (addr_i[31:28] == 4'h1);
  assign ram_idx     = addr_i[IDX_W+1:2];
  assign tx_push     = uart_sel && !addr_i[2] && (we_i != 4'b0000);
  assign status_rd   = uart_sel && addr_i[2] && (we_i == 4'b0000);
  assign unused_addr = ^{addr_i[27:IDX_W+2], addr_i[1:0]};

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (ram_sel && we_i[k]) ram[ram_idx][8*k +: 8] <= wdata_i[8*k +: 8];
    end
  end

  assign status = '{busy: tx_busy_o, overflow: overflow_q, empty: fifo_empty, full: fifo_full};

  always_comb begin
    rd_nxt = '0;
    if (ram_sel)                    rd_nxt = ram[ram_idx];
    else if (uart_sel && addr_i[2]) rd_nxt = {28'b0, status};
  end

  // Overflow is sticky until software reads STATUS; a cycle cannot both set and clear it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rdata_o <= rd_nxt;
      if (tx_push && fifo_full) overflow_q <= 1'b1;
      else if (status_rd)       overflow_q <= 1'b0;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wr_vld (tx_push),
    .wr_dat (wdata_i[7:0]),
    .rd_rdy (fifo_pop),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bit_done = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && bit_cnt == 3'd7) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    uart_tx_o = 1'b1;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE:    fifo_pop  = !fifo_empty;
      START:   uart_tx_o = 1'b0;
      DATA:    uart_tx_o = shift_q[0];
      default: uart_tx_o = 1'b1;
    endcase
  end

  assign tx_busy_o = (state_q != IDLE) || !fifo_empty;

  // Bit-period timer, bit index and shift register; all idle at zero between frames.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
    end else if (state_q == IDLE) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      if (fifo_pop) shift_q <= fifo_rd_dat;
    end else if (bit_done) begin
      clk_cnt <= '0;
      if (state_q == DATA) begin
        shift_q <= shift_q >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_data_bus_bridge.sv
// Bench for data_bus_bridge: directed and random bus traffic against a word-array RAM model
// and a serial-line frame decoder that rebuilds transmitted bytes from uart_tx_o.

module tb_data_bus_bridge;
  localparam int WORDS = 256;
  localparam int DEPTH = 4;
  localparam int CPB   = 4;
  localparam logic [31:0] IDLE_ADDR = 32'h3000_0000;
  localparam logic [31:0] TXDATA    = 32'h1000_0000;
  localparam logic [31:0] STATUS    = 32'h1000_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = IDLE_ADDR;
  logic [31:0] wdata = '0;
  logic [3:0]  we = '0;
  logic [31:0] rdata;
  logic        tx;
  logic        tx_busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0] rx_q [$];
  bit         rx_ok_q [$];
  int         rx_st_q [$];

  data_bus_bridge #(.RAM_WORDS(WORDS), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .we_i      (we),
    .rdata_o   (rdata),
    .uart_tx_o (tx),
    .tx_busy_o (tx_busy)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Serial decoder: a frame is 10 bit periods; every sample within a bit period must agree.
  initial begin
    logic [9:0] bits;
    bit ok;
    bit abort;
    int st;
    forever begin
      @(posedge clk); #1;
      if (rst === 1'b0 && tx === 1'b0) begin
        st = cyc; ok = 1; abort = 0; bits = '0;
        for (int n = 0; n < 10*CPB; n++) begin
          if (n > 0) begin @(posedge clk); #1; end
          if (rst !== 1'b0) abort = 1;
          if (!abort) begin
            if (n % CPB == 0) bits[n/CPB] = tx;
            else if (tx !== bits[n/CPB]) ok = 0;
          end
        end
        if (!abort) begin
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 0;
          rx_q.push_back(bits[8:1]);
          rx_ok_q.push_back(ok);
          rx_st_q.push_back(st);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    addr = a; wdata = d; we = w;
    tick();
    addr = IDLE_ADDR; wdata = '0; we = '0;
  endtask

  task automatic wait_tx_low(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      if (tx === 1'b0) begin seen = 1; break; end
      tick();
    end
  endtask

  task automatic wait_idle(input int bound, output bit seen);
    seen = 0;
    for (int i = 0; i < bound; i++) begin
      if (tx_busy === 1'b0) begin seen = 1; break; end
      tick();
    end
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp);
    logic [31:0] got;
    bit ok;
    got = 32'h100;
    ok = 0;
    if (rx_q.size() > 0) begin
      got = {24'b0, rx_q.pop_front()};
      ok = rx_ok_q.pop_front();
    end
    chk(tag, got, {24'b0, exp});
    chk({tag, "_framing"}, {31'b0, ok}, 32'd1);
  endtask

  logic [31:0] ref_mem [16];
  logic [7:0]  exp_bytes [$];
  logic [7:0]  ovf_bytes [6];
  logic [7:0]  v55;
  logic [31:0] a;
  logic [31:0] d;
  logic [31:0] exp;
  logic [3:0]  w;
  int          idx;
  bit          unm;
  bit          seen;
  int          st0;
  int          st1;

  initial begin
    // Reset state
    #2;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, tx_busy}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    bus(STATUS, '0, 4'b0000);
    chk("rst_status", rdata, 32'h2);

    // Byte lanes, aliasing, TXDATA read
    bus(32'h10, 32'hAABB_CCDD, 4'b1111);
    bus(32'h10, 32'h0000_1100, 4'b0010);
    chk("lane_rbw", rdata, 32'hAABB_CCDD);
    bus(32'h10, '0, 4'b0000);
    chk("lane_merge", rdata, 32'hAABB_11DD);
    bus(32'h10 + WORDS*4, '0, 4'b0000);
    chk("ram_alias", rdata, 32'hAABB_11DD);
    bus(TXDATA, '0, 4'b0000);
    chk("txdata_read", rdata, 32'h0);

    // Read-before-write and unmapped region
    bus(32'h20, 32'hCAFE_F00D, 4'b1111);
    bus(32'h20, 32'h1234_5678, 4'b1111);
    chk("rbw_old", rdata, 32'hCAFE_F00D);
    bus(32'h20, '0, 4'b0000);
    chk("rbw_new", rdata, 32'h1234_5678);
    bus(32'h3000_0000, '0, 4'b0000);
    chk("unmapped_read", rdata, 32'h0);

    // Random RAM traffic against the word model, including unmapped writes that must be dropped
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      bus(32'(i*4), d, 4'b1111);
      ref_mem[i] = d;
    end
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 15);
      d   = $urandom;
      w   = 4'($urandom_range(0, 15));
      unm = ($urandom_range(0, 7) == 0);
      a   = ($urandom & 32'h0FFF_FC03) | 32'(idx << 2);
      if (unm) a[31:28] = 4'($urandom_range(2, 15));
      exp = unm ? 32'h0 : ref_mem[idx];
      bus(a, d, w);
      chk("ram_rand", rdata, exp);
      if (!unm) begin
        for (int k = 0; k < 4; k++) if (w[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
      end
    end
    for (int i = 0; i < 16; i++) begin
      bus(32'(i*4), '0, 4'b0000);
      chk("ram_final", rdata, ref_mem[i]);
    end

    // Single frame 0x55, cycle by cycle
    rx_q.delete(); rx_ok_q.delete(); rx_st_q.delete();
    v55 = 8'h55;
    bus(TXDATA, 32'h55, 4'b0001);
    wait_tx_low(10, seen);
    chk("frame55_start_seen", {31'b0, seen}, 32'd1);
    for (int i = 0; i < 10*CPB; i++) begin
      if (i / CPB == 0)      exp = 32'd0;
      else if (i / CPB == 9) exp = 32'd1;
      else                   exp = {31'b0, v55[i/CPB - 1]};
      chk("frame55_line", {31'b0, tx}, exp);
      tick();
    end
    chk("frame55_busy_drop", {31'b0, tx_busy}, 32'd0);
    chk("frame55_idle_line", {31'b0, tx}, 32'd1);
    check_rx("frame55_rx", 8'h55);

    // Overflow: six back-to-back pushes, one popped at once and four queued, sixth dropped
    rx_q.delete(); rx_ok_q.delete(); rx_st_q.delete();
    for (int i = 0; i < 6; i++) begin
      ovf_bytes[i] = 8'($urandom);
      bus(TXDATA, {24'($urandom), ovf_bytes[i]}, 4'($urandom_range(1, 15)));
    end
    bus(STATUS, '0, 4'b0000);
    chk("ovf_status1", rdata, 32'hD);
    bus(STATUS, '0, 4'b0000);
    chk("ovf_status2", rdata, 32'h9);
    wait_idle(6*10*CPB + 50, seen);
    chk("ovf_drain_seen", {31'b0, seen}, 32'd1);
    repeat (50) tick();
    chk("ovf_frame_count", rx_q.size(), 32'd5);
    for (int i = 0; i + 1 < rx_st_q.size(); i++) begin
      st0 = rx_st_q[i]; st1 = rx_st_q[i+1];
      chk("ovf_frame_gap", 32'(st1 - st0), 32'(10*CPB + 1));
    end
    for (int i = 0; i < 5; i++) check_rx("ovf_rx", ovf_bytes[i]);

    // Pointer wrap: 3*DEPTH sequential bytes then one random batch, pushed in batches of DEPTH
    rx_q.delete(); rx_ok_q.delete(); rx_st_q.delete();
    exp_bytes.delete();
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < DEPTH; j++) begin
        d = (b < 3) ? 32'(b*DEPTH + j) : 32'($urandom_range(0, 255));
        exp_bytes.push_back(d[7:0]);
        bus(TXDATA, d, 4'b0001);
      end
      wait_idle(DEPTH*(10*CPB + 1) + 20, seen);
      chk("wrap_batch_drain", {31'b0, seen}, 32'd1);
    end
    chk("wrap_count", rx_q.size(), 32'(4*DEPTH));
    for (int i = 0; i < 4*DEPTH; i++) check_rx("wrap_rx", exp_bytes[i]);
    bus(STATUS, '0, 4'b0000);
    chk("wrap_status", rdata, 32'h2);
    chk("wrap_busy", {31'b0, tx_busy}, 32'd0);

    // Asynchronous reset in the middle of a data bit
    rx_q.delete(); rx_ok_q.delete(); rx_st_q.delete();
    bus(32'h10, 32'hDEAD_BEEF, 4'b1111);
    bus(TXDATA, 32'hA5, 4'b0001);
    bus(TXDATA, 32'h3C, 4'b0001);
    addr = 32'h10;
    wait_tx_low(10, seen);
    chk("rst_mid_start_seen", {31'b0, seen}, 32'd1);
    repeat (2*CPB) tick();
    chk("rst_mid_pre_rdata", rdata, 32'hDEAD_BEEF);
    chk("rst_mid_pre_tx", {31'b0, tx}, 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_tx", {31'b0, tx}, 32'd1);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_busy", {31'b0, tx_busy}, 32'd0);
    tick(); tick();
    addr = IDLE_ADDR;
    rst = 1'b0;
    bus(STATUS, '0, 4'b0000);
    chk("rst_mid_status", rdata, 32'h2);
    repeat (12*CPB) tick();
    chk("rst_mid_no_frames", rx_q.size(), 32'd0);
    chk("rst_mid_line_idle", {31'b0, tx}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
